// File: rtl/wb_dsp_pkg.sv
// Shared definitions for the Wishbone DSP subsystem.
// Contents: memory/DTB address map constants, the arbiter state enum,
// the latched master command struct and a byte-enable merge helper.
package wb_dsp_pkg;

    localparam int          MEM_AW      = 8;
    localparam logic [31:0] DTB_ADDR    = 32'h0000_0400;
    localparam logic [31:0] UNMAPPED_RD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DAQ_BUS = 2'd1,
        ST_CPU_BUS = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wdata;
    } wb_cmd_t;

    // Replace only the bytes whose enable is set.
    function automatic logic [31:0] apply_sel(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/wb_dsp_top_cmd_port.sv
// Command-driven master port: latches one command on start, holds it
// while active, and finishes on the bus ack for this port.
// Ports: clk/rst, start + command fields in, ack/bus_rdata from the
// shared bus, active/data_rd to the user, cmd (latched command) to arbiter.
module wb_cmd_port
    import wb_dsp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] address,
    input  logic [3:0]  selection,
    input  logic        write,
    input  logic [31:0] data_wr,
    input  logic        ack,
    input  logic [31:0] bus_rdata,
    output logic        active,
    output logic [31:0] data_rd,
    output wb_cmd_t     cmd
);

    logic        active_q, active_d;
    logic [31:0] data_rd_q, data_rd_d;
    wb_cmd_t     cmd_q, cmd_d;

    always_comb begin
        active_d  = active_q;
        data_rd_d = data_rd_q;
        cmd_d     = cmd_q;
        if (!active_q && start) begin
            active_d = 1'b1;
            cmd_d    = '{addr: address, sel: selection, we: write, wdata: data_wr};
        end else if (active_q && ack) begin
            active_d = 1'b0;
            if (!cmd_q.we) data_rd_d = bus_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q  <= 1'b0;
            data_rd_q <= '0;
            cmd_q     <= '0;
        end else begin
            active_q  <= active_d;
            data_rd_q <= data_rd_d;
            cmd_q     <= cmd_d;
        end
    end

    assign active  = active_q;
    assign data_rd = data_rd_q;
    assign cmd     = cmd_q;

endmodule

// File: rtl/wb_dsp_top.sv
// Wishbone DSP subsystem top: two master ports (DAQ has priority over
// CPU) share one bus to a 2^MEM_AW x 32 memory and the DTB register.
// A backdoor file port gives direct single-cycle memory access.
// Ports: clk_pad_i/rst_pad_i, dtb_pad, daq_* and cpu_* command ports,
// file_* backdoor port.
module wb_dsp_top
    import wb_dsp_pkg::*;
(
    input  logic              clk_pad_i,
    input  logic              rst_pad_i,
    output logic [31:0]       dtb_pad,
    input  logic              daq_start,
    input  logic [31:0]       daq_address,
    input  logic [3:0]        daq_selection,
    input  logic              daq_write,
    input  logic [31:0]       daq_data_wr,
    output logic [31:0]       daq_data_rd,
    output logic              daq_active,
    input  logic              cpu_start,
    input  logic [31:0]       cpu_address,
    input  logic [3:0]        cpu_selection,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_data_wr,
    output logic [31:0]       cpu_data_rd,
    output logic              cpu_active,
    input  logic [MEM_AW-1:0] file_num,
    input  logic              file_write,
    input  logic              file_read,
    input  logic [31:0]       file_write_data,
    output logic [31:0]       file_read_data
);

    wb_cmd_t     daq_cmd, cpu_cmd, bus_cmd;
    logic        daq_ack, cpu_ack, bus_cyc;
    arb_state_e  state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d, rd_mux;
    logic [31:0] dtb_q, dtb_d;
    logic [31:0] frd_q, frd_d;
    logic [31:0] mem_q [2**MEM_AW];
    logic        mem_hit, dtb_hit, acc;
    logic [MEM_AW-1:0] bus_idx;
    logic        unused_ok;

    wb_cmd_port u_daq (
        .clk(clk_pad_i), .rst(rst_pad_i), .start(daq_start), .address(daq_address),
        .selection(daq_selection), .write(daq_write), .data_wr(daq_data_wr),
        .ack(daq_ack), .bus_rdata(rdata_q), .active(daq_active),
        .data_rd(daq_data_rd), .cmd(daq_cmd)
    );

    wb_cmd_port u_cpu (
        .clk(clk_pad_i), .rst(rst_pad_i), .start(cpu_start), .address(cpu_address),
        .selection(cpu_selection), .write(cpu_write), .data_wr(cpu_data_wr),
        .ack(cpu_ack), .bus_rdata(rdata_q), .active(cpu_active),
        .data_rd(cpu_data_rd), .cmd(cpu_cmd)
    );

    // Arbiter: state register
    always_ff @(posedge clk_pad_i) begin
        if (rst_pad_i) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Arbiter: next state. A port's active flag doubles as "pending".
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if      (daq_active) state_d = ST_DAQ_BUS;
                else if (cpu_active) state_d = ST_CPU_BUS;
            end
            ST_DAQ_BUS, ST_CPU_BUS: if (ack_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter: bus drive and ack routing
    always_comb begin
        bus_cyc = 1'b0;
        bus_cmd = '0;
        daq_ack = 1'b0;
        cpu_ack = 1'b0;
        case (state_q)
            ST_DAQ_BUS: begin bus_cyc = 1'b1; bus_cmd = daq_cmd; daq_ack = ack_q; end
            ST_CPU_BUS: begin bus_cyc = 1'b1; bus_cmd = cpu_cmd; cpu_ack = ack_q; end
            default: ;
        endcase
    end

    // Slave side: decode on the byte address, low two bits don't matter.
    assign mem_hit   = (bus_cmd.addr[31:MEM_AW+2] == '0);
    assign dtb_hit   = (bus_cmd.addr[31:2] == DTB_ADDR[31:2]);
    assign bus_idx   = bus_cmd.addr[MEM_AW+1:2];
    assign unused_ok = ^bus_cmd.addr[1:0];

    always_comb begin
        if      (mem_hit) rd_mux = mem_q[bus_idx];
        else if (dtb_hit) rd_mux = dtb_q;
        else              rd_mux = UNMAPPED_RD;
    end

    // acc marks the edge that raises ack; the access itself happens there.
    always_comb begin
        ack_d   = bus_cyc && !ack_q;
        acc     = ack_d;
        rdata_d = rdata_q;
        dtb_d   = dtb_q;
        frd_d   = frd_q;
        if (acc && !bus_cmd.we)           rdata_d = rd_mux;
        if (acc && bus_cmd.we && dtb_hit) dtb_d   = apply_sel(dtb_q, bus_cmd.wdata, bus_cmd.sel);
        if (file_read)                    frd_d   = mem_q[file_num];
    end

    always_ff @(posedge clk_pad_i) begin
        if (rst_pad_i) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            dtb_q   <= '0;
            frd_q   <= '0;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            dtb_q   <= dtb_d;
            frd_q   <= frd_d;
        end
    end

    // Memory is never cleared. The backdoor write is issued last so it
    // overrides a bus write to the same word on the same edge.
    always_ff @(posedge clk_pad_i) begin
        if (!rst_pad_i && acc && bus_cmd.we && mem_hit)
            mem_q[bus_idx] <= apply_sel(mem_q[bus_idx], bus_cmd.wdata, bus_cmd.sel);
        if (file_write)
            mem_q[file_num] <= file_write_data;
    end

    assign dtb_pad        = dtb_q;
    assign file_read_data = frd_q;

endmodule

// File: tb/tb_wb_dsp_top.sv
module tb_wb_dsp_top;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dtb_pad;
    logic        daq_start, daq_write, cpu_start, cpu_write;
    logic [31:0] daq_address, daq_data_wr, daq_data_rd;
    logic [31:0] cpu_address, cpu_data_wr, cpu_data_rd;
    logic [3:0]  daq_selection, cpu_selection;
    logic        daq_active, cpu_active;
    logic [7:0]  file_num;
    logic        file_write, file_read;
    logic [31:0] file_write_data, file_read_data;

    int n_cmp = 0;
    int n_fail = 0;

    wb_dsp_top dut (
        .clk_pad_i(clk), .rst_pad_i(rst), .dtb_pad(dtb_pad),
        .daq_start(daq_start), .daq_address(daq_address), .daq_selection(daq_selection),
        .daq_write(daq_write), .daq_data_wr(daq_data_wr), .daq_data_rd(daq_data_rd),
        .daq_active(daq_active),
        .cpu_start(cpu_start), .cpu_address(cpu_address), .cpu_selection(cpu_selection),
        .cpu_write(cpu_write), .cpu_data_wr(cpu_data_wr), .cpu_data_rd(cpu_data_rd),
        .cpu_active(cpu_active),
        .file_num(file_num), .file_write(file_write), .file_read(file_read),
        .file_write_data(file_write_data), .file_read_data(file_read_data)
    );

    always #5 clk = ~clk;

    // one rising edge, then settle; all drive and sample happens here
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input bit is_cpu, input logic [31:0] a, input logic [3:0] s,
                           input logic w, input logic [31:0] d);
        if (is_cpu) begin
            cpu_address = a; cpu_selection = s; cpu_write = w; cpu_data_wr = d;
        end else begin
            daq_address = a; daq_selection = s; daq_write = w; daq_data_wr = d;
        end
    endtask

    // issue one command and return how many cycles active stayed high
    task automatic run_cmd(input bit is_cpu, input logic [31:0] a, input logic [3:0] s,
                           input logic w, input logic [31:0] d, output int n);
        set_cmd(is_cpu, a, s, w, d);
        if (is_cpu) cpu_start = 1'b1; else daq_start = 1'b1;
        cyc();
        cpu_start = 1'b0; daq_start = 1'b0;
        n = 1;
        while ((is_cpu ? cpu_active : daq_active) && n < 20) begin
            cyc();
            if (is_cpu ? cpu_active : daq_active) n++;
        end
    endtask

    task automatic bd_write(input logic [7:0] idx, input logic [31:0] d);
        file_num = idx; file_write_data = d; file_write = 1'b1;
        cyc();
        file_write = 1'b0;
    endtask

    task automatic bd_read(input logic [7:0] idx, output logic [31:0] d);
        file_num = idx; file_read = 1'b1;
        cyc();
        file_read = 1'b0;
        d = file_read_data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        n_cmp++; if ({dtb_pad, daq_data_rd, cpu_data_rd, file_read_data} !== 128'h0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h want 0", dtb_pad, daq_data_rd, cpu_data_rd, file_read_data); end
        n_cmp++; if ({daq_active, cpu_active} !== 2'b00) begin
            n_fail++; $display("FAIL reset_active: got %b want 00", {daq_active, cpu_active}); end
        rst = 1'b0;
        cyc(); cyc(); cyc();
        n_cmp++; if ({daq_active, cpu_active} !== 2'b00) begin
            n_fail++; $display("FAIL idle_active: got %b want 00", {daq_active, cpu_active}); end
    endtask

    task automatic test_cpu_rw();
        int n;
        logic [31:0] d;
        run_cmd(1'b1, 32'h10, 4'hF, 1'b1, 32'hA5A5_1234, n);
        n_cmp++; if (n !== 3) begin n_fail++; $display("FAIL cpu_wr_cycles: got %0d want 3", n); end
        run_cmd(1'b1, 32'h10, 4'hF, 1'b0, 32'h0, n);
        n_cmp++; if (n !== 3) begin n_fail++; $display("FAIL cpu_rd_cycles: got %0d want 3", n); end
        n_cmp++; if (cpu_data_rd !== 32'hA5A5_1234) begin
            n_fail++; $display("FAIL cpu_rd_data: got %h want a5a51234", cpu_data_rd); end
        bd_read(8'd4, d);
        n_cmp++; if (d !== 32'hA5A5_1234) begin n_fail++; $display("FAIL bd_rd_4: got %h want a5a51234", d); end
        cyc();
        n_cmp++; if (file_read_data !== 32'hA5A5_1234) begin
            n_fail++; $display("FAIL bd_rd_hold: got %h want a5a51234", file_read_data); end
    endtask

    task automatic test_dtb();
        int n;
        run_cmd(1'b0, 32'h400, 4'h5, 1'b1, 32'hFFFF_FFFF, n);
        n_cmp++; if (dtb_pad !== 32'h00FF_00FF) begin
            n_fail++; $display("FAIL dtb_wr: got %h want 00ff00ff", dtb_pad); end
        run_cmd(1'b0, 32'h400, 4'hF, 1'b0, 32'h0, n);
        n_cmp++; if (daq_data_rd !== 32'h00FF_00FF) begin
            n_fail++; $display("FAIL dtb_rd: got %h want 00ff00ff", daq_data_rd); end
    endtask

    task automatic test_simultaneous();
        logic [5:0] daq_trace, cpu_trace;
        logic [31:0] d;
        bd_write(8'd0, 32'h11);
        set_cmd(1'b0, 32'h0, 4'hF, 1'b0, 32'h0);
        set_cmd(1'b1, 32'h0, 4'hF, 1'b1, 32'hCAFE);
        daq_start = 1'b1; cpu_start = 1'b1;
        cyc();
        daq_start = 1'b0; cpu_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            daq_trace[k] = daq_active;
            cpu_trace[k] = cpu_active;
        end
        // index k = state after edge E(k+1)
        n_cmp++; if (daq_trace !== 6'b000011) begin
            n_fail++; $display("FAIL sim_daq_active: got %b want 000011", daq_trace); end
        n_cmp++; if (cpu_trace !== 6'b011111) begin
            n_fail++; $display("FAIL sim_cpu_active: got %b want 011111", cpu_trace); end
        n_cmp++; if (daq_data_rd !== 32'h11) begin
            n_fail++; $display("FAIL sim_daq_rd: got %h want 00000011", daq_data_rd); end
        bd_read(8'd0, d);
        n_cmp++; if (d !== 32'hCAFE) begin n_fail++; $display("FAIL sim_bd_rd: got %h want 0000cafe", d); end
    endtask

    task automatic test_unmapped_and_ignore();
        int n, falls, rises;
        logic prev;
        logic [31:0] d;
        run_cmd(1'b1, 32'h8000_0000, 4'hF, 1'b1, 32'hDEAD_BEEF, n);
        n_cmp++; if (n !== 3) begin n_fail++; $display("FAIL unm_wr_cycles: got %0d want 3", n); end
        run_cmd(1'b1, 32'h8000_0000, 4'hF, 1'b0, 32'h0, n);
        n_cmp++; if (cpu_data_rd !== 32'h0) begin
            n_fail++; $display("FAIL unm_rd: got %h want 00000000", cpu_data_rd); end
        bd_read(8'd0, d);
        n_cmp++; if (d !== 32'hCAFE || dtb_pad !== 32'h00FF_00FF) begin
            n_fail++; $display("FAIL unm_wr_dropped: got mem0=%h dtb=%h want 0000cafe 00ff00ff", d, dtb_pad); end
        // second start while busy must not launch another command
        bd_write(8'd8, 32'h0);
        set_cmd(1'b0, 32'h10, 4'hF, 1'b0, 32'h0);
        daq_start = 1'b1;
        cyc();
        daq_start = 1'b0;
        cyc();
        set_cmd(1'b0, 32'h20, 4'hF, 1'b1, 32'h77);
        daq_start = 1'b1;
        cyc();
        daq_start = 1'b0;
        falls = 0; rises = 0; prev = daq_active;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (prev && !daq_active) falls++;
            if (!prev && daq_active) rises++;
            prev = daq_active;
        end
        n_cmp++; if (falls !== 1 || rises !== 0) begin
            n_fail++; $display("FAIL busy_start: got falls=%0d rises=%0d want 1 0", falls, rises); end
        n_cmp++; if (daq_data_rd !== 32'hA5A5_1234) begin
            n_fail++; $display("FAIL busy_rd: got %h want a5a51234", daq_data_rd); end
        bd_read(8'd8, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL busy_no_wr: got %h want 00000000", d); end
    endtask

    task automatic test_backdoor_prio();
        logic [31:0] d;
        // bus write to word 10 acks on E2; backdoor write on the same edge wins
        set_cmd(1'b1, 32'h28, 4'hF, 1'b1, 32'h1111);
        cpu_start = 1'b1;
        cyc();
        cpu_start = 1'b0;
        cyc();
        file_num = 8'd10; file_write_data = 32'h2222; file_write = 1'b1;
        cyc();
        file_write = 1'b0;
        cyc(); cyc();
        bd_read(8'd10, d);
        n_cmp++; if (d !== 32'h2222) begin n_fail++; $display("FAIL bd_prio: got %h want 00002222", d); end
        // read and write same index on one edge returns old data
        file_num = 8'd10; file_write_data = 32'h3333; file_write = 1'b1; file_read = 1'b1;
        cyc();
        file_write = 1'b0; file_read = 1'b0;
        n_cmp++; if (file_read_data !== 32'h2222) begin
            n_fail++; $display("FAIL bd_rd_old: got %h want 00002222", file_read_data); end
    endtask

    task automatic test_reset_midflight();
        int n;
        logic [31:0] d;
        bd_write(8'd9, 32'h0000_1234);
        set_cmd(1'b1, 32'h24, 4'hF, 1'b1, 32'hBEEF);
        cpu_start = 1'b1;
        cyc();
        cpu_start = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++; if (cpu_active !== 1'b0) begin n_fail++; $display("FAIL rst_mid_active: got %b want 0", cpu_active); end
        cyc(); cyc(); cyc();
        bd_read(8'd9, d);
        n_cmp++; if (d !== 32'h0000_1234) begin n_fail++; $display("FAIL rst_mid_mem: got %h want 00001234", d); end
        run_cmd(1'b1, 32'h24, 4'h3, 1'b1, 32'h5555_AAAA, n);
        n_cmp++; if (n !== 3) begin n_fail++; $display("FAIL rst_next_cycles: got %0d want 3", n); end
        bd_read(8'd9, d);
        n_cmp++; if (d !== 32'h0000_AAAA) begin n_fail++; $display("FAIL rst_next_sel: got %h want 0000aaaa", d); end
    endtask

    initial begin
        rst = 1'b1;
        daq_start = 1'b0; daq_address = '0; daq_selection = '0; daq_write = 1'b0; daq_data_wr = '0;
        cpu_start = 1'b0; cpu_address = '0; cpu_selection = '0; cpu_write = 1'b0; cpu_data_wr = '0;
        file_num = '0; file_write = 1'b0; file_read = 1'b0; file_write_data = '0;
        #1;
        test_reset();
        test_cpu_rw();
        test_dtb();
        test_simultaneous();
        test_unmapped_and_ignore();
        test_backdoor_prio();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
